// File: rtl/ts_packet_gen_if.sv
// ts_packet_gen_if: byte-stream link between a TS packet source and its sink.
// The master drives valid/syn/ts_data; the slave drives ready back-pressure.
interface ts_packet_gen_if;
  logic       valid;
  logic       syn;
  logic [7:0] ts_data;
  logic       ready;

  modport master (output valid, output syn, output ts_data, input ready);
  modport slave  (input valid, input syn, input ts_data, output ready);
endinterface

// File: rtl/ts_packet_gen.sv
// ts_packet_gen: MPEG-2 TS packet source.
// It emits PKT_LEN-byte packets: a 4-byte header (sync 0x47, PUSI/PID, continuity
// counter), then a payload taken from a free-running byte pattern. An idle gap of
// GAP_CYCLES cycles separates packets. The stream obeys a valid/ready handshake.
// Optional build macro TS_NULL_INSERT_EN: while enable is low the block sends
// null packets (PID 0x1FFF, payload 0xFF) instead of going silent.
// pkt_done and pkt_count are registered. Both update in the cycle after the
// last byte's handshake.
module ts_packet_gen #(
  parameter int         PKT_LEN    = 188,
  parameter int         GAP_CYCLES = 4,
  parameter logic [7:0] PAT_SEED   = 8'h00
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [12:0]           pid,
  input  logic                  pusi,
  ts_packet_gen_if.master       ts,
  output logic                  pkt_done,
  output logic [31:0]           pkt_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HDR     = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam bit         GAP_NONE = (GAP_CYCLES == 0);

  logic [1:0]  rst_pipe_r;
  logic        rst_int_s;
  logic [1:0]  state_r, state_s;
  logic [7:0]  idx_r, idx_s;
  logic [7:0]  pat_r, pat_s;
  logic [3:0]  cc_r, cc_s;
  logic [12:0] pid_r, pid_s;
  logic        pusi_r, pusi_s;
  logic        null_r, null_s;
  logic [7:0]  gap_r, gap_s;
  logic        done_s;
  logic [31:0] count_s;
  logic        start_s;
  logic        accept_s;
  logic        valid_s;
  logic        syn_s;
  logic [7:0]  data_s;

  // Return the packet byte at a given index. Null packets have a fixed header
  // and an all-0xFF payload.
  function automatic logic [7:0] pkt_byte(input logic [7:0] idx, input logic [12:0] p,
                                          input logic pu, input logic [3:0] cc,
                                          input logic [7:0] pat, input logic is_null);
    logic [7:0] b;
    if (is_null) begin
      case (idx)
        8'd0:    b = 8'h47;
        8'd1:    b = 8'h1F;
        8'd2:    b = 8'hFF;
        8'd3:    b = 8'h10;
        default: b = 8'hFF;
      endcase
    end else begin
      case (idx)
        8'd0:    b = 8'h47;
        8'd1:    b = {1'b0, pu, 1'b0, p[12:8]};
        8'd2:    b = p[7:0];
        8'd3:    b = {2'b00, 2'b01, cc};
        default: b = pat;
      endcase
    end
    return b;
  endfunction

  // Reset synchroniser: reset asserts at once and releases on the clock edge.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe_r <= 2'b00;
    end else begin
      rst_pipe_r <= {rst_pipe_r[0], 1'b1};
    end
  end

  assign rst_int_s = rst_pipe_r[1];
  assign accept_s  = ts.valid && ts.ready;

  // Next-state logic. The outputs are computed from the next state, so the
  // registered byte always matches the state being entered.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    pat_s   = pat_r;
    cc_s    = cc_r;
    pid_s   = pid_r;
    pusi_s  = pusi_r;
    null_s  = null_r;
    gap_s   = gap_r;
    done_s  = 1'b0;
    count_s = pkt_count;
    start_s = 1'b0;
    case (state_r)
      IDLE: begin
        start_s = 1'b1;
      end
      HDR, PAYLOAD: begin
        if (accept_s) begin
          if (state_r == PAYLOAD && !null_r) begin
            pat_s = pat_r + 8'd1;
          end else begin
            pat_s = pat_r;
          end
          if (idx_r == LAST_IDX) begin
            done_s = 1'b1;
            if (!null_r) begin
              count_s = pkt_count + 32'd1;
              cc_s    = cc_r + 4'd1;
            end else begin
              count_s = pkt_count;
            end
            if (GAP_NONE) begin
              start_s = 1'b1;
            end else begin
              state_s = GAP;
              gap_s   = 8'd0;
            end
          end else begin
            idx_s = idx_r + 8'd1;
            if (idx_r == 8'd3) begin
              state_s = PAYLOAD;
            end else begin
              state_s = state_r;
            end
          end
        end else begin
          state_s = state_r;
        end
      end
      GAP: begin
        if (gap_r == GAP_LAST) begin
          start_s = 1'b1;
        end else begin
          gap_s = gap_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (start_s) begin
      idx_s = 8'd0;
      if (enable) begin
        pid_s   = pid;
        pusi_s  = pusi;
        null_s  = 1'b0;
        state_s = HDR;
      end else begin
`ifdef TS_NULL_INSERT_EN
        null_s  = 1'b1;
        state_s = HDR;
`else
        null_s  = 1'b0;
        state_s = IDLE;
`endif
      end
    end else begin
      idx_s = idx_s;
    end

    valid_s = (state_s == HDR) || (state_s == PAYLOAD);
    syn_s   = (state_s == HDR) && (idx_s == 8'd0);
    if (valid_s) begin
      data_s = pkt_byte(idx_s, pid_s, pusi_s, cc_s, pat_s, null_s);
    end else begin
      data_s = 8'h00;
    end
  end

  // State and registered output update.
  always_ff @(posedge wclk or negedge rst_int_s) begin
    if (!rst_int_s) begin
      state_r    <= IDLE;
      idx_r      <= 8'd0;
      pat_r      <= PAT_SEED;
      cc_r       <= 4'd0;
      pid_r      <= 13'd0;
      pusi_r     <= 1'b0;
      null_r     <= 1'b0;
      gap_r      <= 8'd0;
      ts.valid   <= 1'b0;
      ts.syn     <= 1'b0;
      ts.ts_data <= 8'h00;
      pkt_done   <= 1'b0;
      pkt_count  <= 32'd0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      pat_r      <= pat_s;
      cc_r       <= cc_s;
      pid_r      <= pid_s;
      pusi_r     <= pusi_s;
      null_r     <= null_s;
      gap_r      <= gap_s;
      ts.valid   <= valid_s;
      ts.syn     <= syn_s;
      ts.ts_data <= data_s;
      pkt_done   <= done_s;
      pkt_count  <= count_s;
    end
  end

endmodule
